// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM encoding and fetch-path constants.
package cpu_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT      = 2'd1,
    WAIT_DROP = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          WORD_BYTES       = 4;

endpackage

// File: rtl/fetch_unit_if.sv
// Instruction memory read port: request/ready handshake plus response channel.
interface fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (
    output imem_req, imem_addr,
    input  imem_ready, imem_rvalid, imem_rdata
  );

  modport slave (
    input  imem_req, imem_addr,
    output imem_ready, imem_rvalid, imem_rdata
  );
endinterface

// File: rtl/fetch_queue.sv
// Small circular FIFO of {pc, ir} pairs with synchronous clear.
module fetch_queue #(
  parameter int QDEPTH = 2
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic                          push,
  input  logic [63:0]                   push_data,
  input  logic                          pop,
  output logic [$clog2(QDEPTH+1)-1:0]   count,
  output logic [63:0]                   head
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(QDEPTH - 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  logic [63:0]      mem [QDEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [63:0]      last_q;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      last_q <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop) begin
        rd_ptr <= ptr_inc(rd_ptr);
        last_q <= mem[rd_ptr];
      end
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset: an entry is only read after it was written.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= push_data;
  end

  // When empty, keep presenting the most recently consumed pair.
  assign head = (count != '0) ? mem[rd_ptr] : last_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch front end: owns the fetch PC, issues one outstanding imem
// read at a time and queues returned {PC, IR} pairs for the IF/ID register.
//
// state     | meaning
// IDLE      | no request outstanding; may issue when queue has room
// WAIT      | request accepted, response will be queued
// WAIT_DROP | request accepted, response belongs to a flushed path
module fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               CLR,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               stall,
  fetch_unit_if.master       imem,
  output logic               valid,
  output logic [31:0]        IR,
  output logic [31:0]        PC
);

  localparam int CNT_W = $clog2(QDEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(QDEPTH);

  fetch_state_t     state, state_next;
  logic [31:0]      fpc, req_pc;
  logic             req, accept, push, pop;
  logic [CNT_W-1:0] count;
  logic [63:0]      head;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) state <= IDLE;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:      if (accept) state_next = WAIT;
      WAIT: begin
        if (redirect) state_next = imem.imem_rvalid ? IDLE : WAIT_DROP;
        else if (imem.imem_rvalid) state_next = IDLE;
      end
      WAIT_DROP: if (imem.imem_rvalid) state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  // Request is gated by the reset pin so it is low for the whole reset window.
  always_comb begin
    req    = CLR && (state == IDLE) && (count < FULL_CNT) && !redirect;
    accept = req && imem.imem_ready;
    push   = (state == WAIT) && imem.imem_rvalid && !redirect;
    pop    = valid && !stall;
  end

  assign imem.imem_req  = req;
  assign imem.imem_addr = fpc;

  always_ff @(posedge clk or negedge CLR) begin
    if (!CLR) begin
      fpc    <= RESET_PC;
      req_pc <= '0;
    end else if (redirect) begin
      fpc <= redirect_pc & ~32'h0000_0003;
    end else if (accept) begin
      fpc    <= fpc + 32'(WORD_BYTES);
      req_pc <= fpc;
    end
  end

  fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst_n     (CLR),
    .clear     (redirect),
    .push      (push),
    .push_data ({req_pc, imem.imem_rdata}),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign valid = (count != '0);
  assign PC    = head[63:32];
  assign IR    = head[31:0];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, stall, redirect, ready backpressure,
// mid-request reset and fetch-address wrap.
module tb_fetch_unit;

  logic        clk;
  logic        clr_n;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        valid, valid2;
  logic [31:0] IR, PC, IR2, PC2;

  int checks = 0;
  int errors = 0;

  logic        auto_mem;
  logic        acc;
  logic [31:0] acc_addr;

  fetch_unit_if ifc ();
  fetch_unit_if ifc2 ();

  fetch_unit dut (
    .clk         (clk),
    .CLR         (clr_n),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .imem        (ifc),
    .valid       (valid),
    .IR          (IR),
    .PC          (PC)
  );

  fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk         (clk),
    .CLR         (clr_n),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .stall       (1'b0),
    .imem        (ifc2),
    .valid       (valid2),
    .IR          (IR2),
    .PC          (PC2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; with auto_mem set, acts as a 1-cycle memory returning addr+0x1000.
  task automatic tick();
    #2;
    acc      = ifc.imem_req && ifc.imem_ready;
    acc_addr = ifc.imem_addr;
    @(posedge clk);
    #1;
    if (auto_mem) begin
      ifc.imem_rvalid = acc;
      ifc.imem_rdata  = acc_addr + 32'h1000;
    end
  endtask

  initial begin
    clr_n = 1'b0; redirect = 1'b0; redirect_pc = '0; stall = 1'b0; auto_mem = 1'b1;
    ifc.imem_ready = 1'b1; ifc.imem_rvalid = 1'b0; ifc.imem_rdata = '0;
    ifc2.imem_ready = 1'b0; ifc2.imem_rvalid = 1'b0; ifc2.imem_rdata = '0;

    #16;
    chk("rst_valid", valid, 0);
    chk("rst_ir", IR, 0);
    chk("rst_pc", PC, 0);
    chk("rst_req", ifc.imem_req, 0);
    clr_n = 1'b1;
    #1;
    chk("rel_req", ifc.imem_req, 1);
    chk("rel_addr", ifc.imem_addr, 32'h0);

    // Streaming with 1-cycle memory: one instruction every 2 cycles.
    tick(); chk("s0_req_wait", ifc.imem_req, 0);
    tick(); chk("s0_valid", valid, 1); chk("s0_pc", PC, 32'h0); chk("s0_ir", IR, 32'h1000);
    chk("s0_next_addr", ifc.imem_addr, 32'h4);
    tick(); chk("s1_gap", valid, 0);
    tick(); chk("s1_valid", valid, 1); chk("s1_pc", PC, 32'h4); chk("s1_ir", IR, 32'h1004);
    tick(); chk("s2_gap", valid, 0);
    tick(); chk("s2_valid", valid, 1); chk("s2_pc", PC, 32'h8); chk("s2_ir", IR, 32'h1008);

    // Stall IF/ID for 10 cycles: queue fills to 2 and fetch stops.
    stall = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    chk("full_req", ifc.imem_req, 0);
    chk("full_pc", PC, 32'h8);
    stall = 1'b0;
    tick(); chk("drain_pc0", PC, 32'hC); chk("drain_ir0", IR, 32'h100C); chk("drain_valid", valid, 1);
    chk("reissue_req", ifc.imem_req, 1); chk("reissue_addr", ifc.imem_addr, 32'h10);
    tick(); chk("drain_empty", valid, 0);
    tick(); chk("resume_pc", PC, 32'h10); chk("resume_ir", IR, 32'h1010);

    // Redirect while a request is outstanding: its response must be dropped.
    auto_mem = 1'b0;
    tick();
    redirect = 1'b1; redirect_pc = 32'h0000_0043;
    tick();
    redirect = 1'b0;
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'hDEAD_BEEF;
    #1;
    chk("drop_req", ifc.imem_req, 0);
    chk("drop_valid0", valid, 0);
    tick();
    ifc.imem_rvalid = 1'b0;
    #1;
    chk("drop_valid1", valid, 0);
    chk("redir_req", ifc.imem_req, 1);
    chk("redir_addr", ifc.imem_addr, 32'h40);
    auto_mem = 1'b1;
    tick();
    tick(); chk("redir_valid", valid, 1); chk("redir_pc", PC, 32'h40); chk("redir_ir", IR, 32'h1040);

    // Redirect coinciding with the response, with a live entry held by stall.
    stall = 1'b1;
    tick(); chk("same_hold", PC, 32'h40);
    redirect = 1'b1; redirect_pc = 32'h0000_0100;
    tick();
    redirect = 1'b0; stall = 1'b0;
    #1;
    chk("same_valid", valid, 0);
    chk("same_req", ifc.imem_req, 1);
    chk("same_addr", ifc.imem_addr, 32'h100);
    tick();
    tick(); chk("same_pc", PC, 32'h100); chk("same_ir", IR, 32'h1100);

    // Memory not ready: address held, fetch PC frozen.
    ifc.imem_ready = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("nrdy_req", ifc.imem_req, 1);
      chk("nrdy_addr", ifc.imem_addr, 32'h104);
    end
    ifc.imem_ready = 1'b1;
    tick();
    tick();
    stall = 1'b0;
    tick();
    chk("nrdy_pc", PC, 32'h104); chk("nrdy_ir", IR, 32'h1104);
    chk("nrdy_next", ifc.imem_addr, 32'h108);

    // Reset asserted mid-request; the late response must be ignored.
    stall = 1'b1; auto_mem = 1'b0;
    tick();
    chk("pre_rst_valid", valid, 1);
    #2 clr_n = 1'b0;
    #1;
    chk("arst_valid", valid, 0); chk("arst_ir", IR, 0); chk("arst_pc", PC, 0);
    chk("arst_req", ifc.imem_req, 0);
    tick();
    clr_n = 1'b1; stall = 1'b0;
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h0000_BAD0;
    #1;
    chk("post_rst_req", ifc.imem_req, 1);
    chk("post_rst_addr", ifc.imem_addr, 32'h0);
    tick();
    ifc.imem_rvalid = 1'b0;
    #1;
    chk("late_ignored", valid, 0);
    ifc.imem_rvalid = 1'b1; ifc.imem_rdata = 32'h2000;
    tick();
    ifc.imem_rvalid = 1'b0;
    #1;
    chk("post_rst_valid", valid, 1); chk("post_rst_pc", PC, 32'h0); chk("post_rst_ir", IR, 32'h2000);

    // Fetch address wraps from the top of the address space.
    chk("wrap_req0", ifc2.imem_req, 1);
    chk("wrap_addr0", ifc2.imem_addr, 32'hFFFF_FFFC);
    ifc2.imem_ready = 1'b1;
    tick();
    ifc2.imem_ready = 1'b0;
    ifc2.imem_rvalid = 1'b1; ifc2.imem_rdata = 32'h1234_5678;
    tick();
    ifc2.imem_rvalid = 1'b0;
    #1;
    chk("wrap_addr1", ifc2.imem_addr, 32'h0);
    chk("wrap_req1", ifc2.imem_req, 1);
    chk("wrap_pc", PC2, 32'hFFFF_FFFC);
    chk("wrap_ir", IR2, 32'h1234_5678);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
